// File: rtl/vga_rect_fill_master.sv
// ---------------------------------------------------------------------------
// vga_rect_fill_master
//
// Avalon-MM write initiator that paints a filled, screen-clipped rectangle by
// issuing one plot write per pixel to the vga_avalon pixel-plot responder
// (register address 0). The rectangle is walked in row-major order: x runs
// from x0 to the clipped right edge, then y steps down one row.
//
// Handshake: a write is offered by holding master_write=1 with a stable
// master_address/master_writedata. It is accepted on a rising clock edge
// where master_write=1 and master_waitrequest=0. While master_waitrequest=1
// nothing on the request side changes.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   start               one-cycle request, sampled only while idle
//   x0, y0              top-left corner (inclusive)
//   x1, y1              bottom-right corner (inclusive, clipped to screen)
//   colour              3-bit colour used for every pixel of the fill
//   busy                high while the block is issuing writes
//   done                one-cycle completion pulse
//   master_address      always 4'd0 (plot register)
//   master_write        Avalon write request
//   master_writedata    {13'b0, colour, 1'b0, y[6:0], x[7:0]}
//   master_waitrequest  responder stall
//   dbg_state           current FSM state (0 idle, 1 write, 2 done)
// ---------------------------------------------------------------------------
module vga_rect_fill_master #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    input  logic [7:0]  x1,
    input  logic [6:0]  y1,
    input  logic [2:0]  colour,
    output logic        busy,
    output logic        done,
    output logic [3:0]  master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest,
    output logic [1:0]  dbg_state
);

    // Last visible column / row, sized to the coordinate ports.
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Latched request.
    logic [7:0]  x0_q,     x0_d;
    logic [6:0]  y0_q,     y0_d;
    logic [7:0]  ex1_q,    ex1_d;      // clipped right edge
    logic [6:0]  ey1_q,    ey1_d;      // clipped bottom edge
    logic [2:0]  colour_q, colour_d;

    // Walk position; these also form the write payload.
    logic [7:0]  cur_x_q,  cur_x_d;
    logic [6:0]  cur_y_q,  cur_y_d;

    // Registered handshake/status outputs.
    logic        write_q,  write_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    // Clipped corners of the incoming request.
    logic [7:0]  clip_x1;
    logic [6:0]  clip_y1;
    logic        req_empty;
    logic        accept;

    always_comb begin
        clip_x1   = (x1 > X_MAX) ? X_MAX : x1;
        clip_y1   = (y1 > Y_MAX) ? Y_MAX : y1;
        // Inverted corners, or a left/top edge already past the screen,
        // leave nothing to draw.
        req_empty = (x0 > clip_x1) || (y0 > clip_y1);
    end

    // write_q is high exactly in S_WRITE, so acceptance reduces to the
    // responder not stalling.
    assign accept = write_q & ~master_waitrequest;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        ex1_d    = ex1_q;
        ey1_d    = ey1_q;
        colour_d = colour_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    ex1_d    = clip_x1;
                    ey1_d    = clip_y1;
                    colour_d = colour;
                    cur_x_d  = x0;
                    cur_y_d  = y0;
                    state_d  = req_empty ? S_DONE : S_WRITE;
                end
            end

            S_WRITE: begin
                if (accept) begin
                    if (cur_x_q < ex1_q) begin
                        cur_x_d = cur_x_q + 8'd1;
                    end else if (cur_y_q < ey1_q) begin
                        cur_x_d = x0_q;
                        cur_y_d = cur_y_q + 7'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight
        // out of flops in the cycle the state is entered.
        write_d = (state_d == S_WRITE);
        busy_d  = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x0_q     <= 8'd0;
            y0_q     <= 7'd0;
            ex1_q    <= 8'd0;
            ey1_q    <= 7'd0;
            colour_q <= 3'd0;
            cur_x_q  <= 8'd0;
            cur_y_q  <= 7'd0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            ex1_q    <= ex1_d;
            ey1_q    <= ey1_d;
            colour_q <= colour_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign master_address   = 4'd0;
    assign master_write     = write_q;
    assign master_writedata = {13'b0, colour_q, 1'b0, cur_y_q, cur_x_q};
    assign busy             = busy_q;
    assign done             = done_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_vga_rect_fill_master.sv
module tb_vga_rect_fill_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [7:0]  x1;
    logic [6:0]  y1;
    logic [2:0]  colour;
    logic        busy;
    logic        done;
    logic [3:0]  master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_errors;

    // Scoreboard: expected pixel writes vs. writes seen accepted.
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];
    int          done_cnt;
    int          busy_cnt;
    int          wr_cycles;
    int          clip_bad;

    vga_rect_fill_master #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .x0                 (x0),
        .y0                 (y0),
        .x1                 (x1),
        .y1                 (y1),
        .colour             (colour),
        .busy               (busy),
        .done               (done),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor (mid-cycle) ----------------
    // Inputs change 2 time units after the rising edge, so at the falling
    // edge everything is settled: a write offered with waitrequest low is
    // taken on the following rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (master_write && !master_waitrequest) begin
                acc_q.push_back(master_writedata);
                if (master_writedata[7:0] >= 8'd160 || master_writedata[14:8] >= 7'd120)
                    clip_bad++;
            end
            if (master_write) wr_cycles++;
            if (busy)         busy_cnt++;
            if (done)         done_cnt++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, req);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        acc_q.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        wr_cycles = 0;
        clip_bad  = 0;
    endtask

    function automatic logic [31:0] pix(input int x, input int y, input logic [2:0] c);
        logic [7:0] xb;
        logic [6:0] yb;
        xb = 8'(x);
        yb = 7'(y);
        return {13'b0, c, 1'b0, yb, xb};
    endfunction

    // Reference walk of the clipped rectangle.
    task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1,
                             input logic [2:0] c);
        int ex, ey;
        ex = (ax1 > 159) ? 159 : ax1;
        ey = (ay1 > 119) ? 119 : ay1;
        for (int y = ay0; y <= ey; y++)
            for (int x = ax0; x <= ex; x++)
                exp_q.push_back(pix(x, y, c));
    endtask

    // Called just after a rising edge; leaves start asserted across exactly
    // one edge and returns 2 time units after that edge.
    task automatic start_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                              input logic [2:0] c);
        x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        colour = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd0; y1 = 7'd0; colour = 3'd0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        if (!done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic compare_sb(input string tag);
        check({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            check($sformatf("%s_px%0d", tag, i), acc_q[i], exp_q[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        start = 1'b0;
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd0; y1 = 7'd0; colour = 3'd0;
        master_waitrequest = 1'b0;
        clear_sb();

        // Reset state.
        tick();
        tick();
        check("rst_write", {31'd0, master_write}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_wdata", master_writedata, 32'd0);
        check("rst_addr",  {28'd0, master_address}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        tick();
        tick();

        // Single pixel: one write, done two cycles after start, busy 1 cycle.
        clear_sb();
        build_exp(1, 1, 1, 1, 3'b111);
        start_fill(1, 1, 1, 1, 3'b111);
        check("sp_write_n1", {31'd0, master_write}, 32'd1);
        check("sp_busy_n1",  {31'd0, busy}, 32'd1);
        check("sp_done_n1",  {31'd0, done}, 32'd0);
        check("sp_wdata",    master_writedata, 32'h0007_0101);
        tick();
        check("sp_done_n2",  {31'd0, done}, 32'd1);
        check("sp_busy_n2",  {31'd0, busy}, 32'd0);
        check("sp_write_n2", {31'd0, master_write}, 32'd0);
        tick();
        check("sp_done_n3",  {31'd0, done}, 32'd0);
        tick();
        compare_sb("sp");
        check("sp_busy_cycles", 32'(busy_cnt), 32'd1);
        check("sp_done_cnt", 32'(done_cnt), 32'd1);

        // 2x2 with a 2-cycle stall on the second write.
        clear_sb();
        build_exp(2, 5, 3, 6, 3'b101);
        start_fill(2, 5, 3, 6, 3'b101);
        check("st_px0_live", master_writedata, pix(2, 5, 3'b101));
        tick();
        master_waitrequest = 1'b1;
        check("st_hold0", master_writedata, pix(3, 5, 3'b101));
        tick();
        check("st_hold1", master_writedata, pix(3, 5, 3'b101));
        check("st_hold_wr", {31'd0, master_write}, 32'd1);
        tick();
        check("st_hold2", master_writedata, pix(3, 5, 3'b101));
        master_waitrequest = 1'b0;
        wait_done("st");
        check("st_done_no_write", {31'd0, master_write}, 32'd0);
        tick();
        tick();
        compare_sb("st");
        check("st_done_cnt", 32'(done_cnt), 32'd1);

        // Clipping at the bottom-right corner.
        clear_sb();
        build_exp(158, 119, 200, 127, 3'b010);
        start_fill(158, 119, 200, 127, 3'b010);
        wait_done("cl");
        tick();
        tick();
        compare_sb("cl");
        check("cl_offscreen", 32'(clip_bad), 32'd0);

        // Inverted rectangle: done in N+1, never a write.
        clear_sb();
        start_fill(10, 3, 5, 4, 3'b001);
        check("em_done_n1", {31'd0, done}, 32'd1);
        check("em_write_n1", {31'd0, master_write}, 32'd0);
        tick();
        tick();
        check("em_wr_cycles", 32'(wr_cycles), 32'd0);
        check("em_busy_cycles", 32'(busy_cnt), 32'd0);
        check("em_done_cnt", 32'(done_cnt), 32'd1);

        // Start re-pulsed while busy is ignored.
        clear_sb();
        build_exp(20, 30, 23, 30, 3'b011);
        start_fill(20, 30, 23, 30, 3'b011);
        tick();
        start_fill(50, 60, 70, 80, 3'b110);
        wait_done("sb");
        tick();
        tick();
        tick();
        compare_sb("sb");
        check("sb_done_cnt", 32'(done_cnt), 32'd1);

        // Reset after the third acceptance of a 10-pixel fill.
        clear_sb();
        start_fill(0, 0, 9, 0, 3'b100);
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rm_write_now", {31'd0, master_write}, 32'd0);
        check("rm_busy_now",  {31'd0, busy}, 32'd0);
        check("rm_done_now",  {31'd0, done}, 32'd0);
        check("rm_wdata_now", master_writedata, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rm_accepted", 32'(acc_q.size()), 32'd3);
        check("rm_no_done", 32'(done_cnt), 32'd0);
        check("rm_idle", {30'd0, dbg_state}, 32'd0);
        check("rm_write_idle", {31'd0, master_write}, 32'd0);

        // Recovery after reset.
        clear_sb();
        build_exp(5, 7, 6, 7, 3'b001);
        start_fill(5, 7, 6, 7, 3'b001);
        wait_done("rc");
        tick();
        compare_sb("rc");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach end of stimulus");
        $fatal(1);
    end

endmodule
